// File: rtl/sdram_cache.sv
// rtl/sdram_cache.sv - direct-mapped write-through word cache in front of the SDRAM controller
module sdram_cache #(
  parameter int INDEX_BITS = 7,
  parameter int ADDR_BITS  = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_start,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [31:0]          cpu_data,
  output logic [31:0]          cpu_q,
  output logic                 cpu_done,
  input  logic                 cache_clear,
  output logic                 sdram_start,
  output logic                 sdram_we,
  output logic [ADDR_BITS-1:0] sdram_addr,
  output logic [31:0]          sdram_d,
  input  logic [31:0]          sdram_q,
  input  logic                 sdram_q_ready,
  input  logic                 sdram_busy,
  input  logic                 sdram_init_done,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
);

  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, MEM_WAIT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   req_addr_q, req_addr_d;
  logic                   req_we_q, req_we_d;
  logic [31:0]            req_data_q, req_data_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   done_q, done_d;
  logic                   start_q, start_d;
  logic                   swe_q, swe_d;
  logic [ADDR_BITS-1:0]   saddr_q, saddr_d;
  logic [31:0]            sdata_q, sdata_d;
  logic [15:0]            hit_cnt_q, hit_cnt_d;
  logic [15:0]            miss_cnt_q, miss_cnt_d;

  logic [31:0]            data_mem [LINES];
  logic [TAG_BITS-1:0]    tag_mem  [LINES];
  logic                   line_we, tag_we;
  logic [31:0]            line_wdata;

  logic [INDEX_BITS-1:0]  req_idx;
  logic [TAG_BITS-1:0]    req_tag;
  logic                   hit;

  assign req_idx = req_addr_q[INDEX_BITS-1:0];
  assign req_tag = req_addr_q[ADDR_BITS-1:INDEX_BITS];
  assign hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_we_d   = req_we_q;
    req_data_d = req_data_q;
    valid_d    = valid_q;
    rdata_d    = rdata_q;
    done_d     = done_q;
    start_d    = start_q;
    swe_d      = swe_q;
    saddr_d    = saddr_q;
    sdata_d    = sdata_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    line_we    = 1'b0;
    tag_we     = 1'b0;
    line_wdata = req_data_q;

    case (state_q)
      IDLE: begin
        if (cache_clear) begin
          valid_d = '0;
        end else if (cpu_start) begin
          req_addr_d = cpu_addr;
          req_we_d   = cpu_we;
          req_data_d = cpu_data;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!req_we_q) begin
          if (hit) begin
            rdata_d   = data_mem[req_idx];
            hit_cnt_d = hit_cnt_q + 16'd1;
            done_d    = 1'b1;
            state_d   = DONE;
          end else begin
            miss_cnt_d = miss_cnt_q + 16'd1;
            state_d    = MEM_REQ;
          end
        end else begin
          // No-write-allocate: only a line already holding this tag is refreshed.
          line_we = hit;
          state_d = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (sdram_init_done && !sdram_busy) begin
          start_d = 1'b1;
          swe_d   = req_we_q;
          saddr_d = req_addr_q;
          sdata_d = req_data_q;
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (sdram_q_ready) begin
          start_d = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
          if (!req_we_q) begin
            rdata_d          = sdram_q;
            line_we          = 1'b1;
            line_wdata       = sdram_q;
            tag_we           = 1'b1;
            valid_d[req_idx] = 1'b1;
          end
        end
      end
      DONE: begin
        if (!cpu_start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      req_we_q   <= 1'b0;
      req_data_q <= '0;
      valid_q    <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
      swe_q      <= 1'b0;
      saddr_q    <= '0;
      sdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      req_we_q   <= req_we_d;
      req_data_q <= req_data_d;
      valid_q    <= valid_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      start_q    <= start_d;
      swe_q      <= swe_d;
      saddr_q    <= saddr_d;
      sdata_q    <= sdata_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Line storage needs no reset; the valid vector alone decides what is live.
  always_ff @(posedge clk) begin
    if (line_we) data_mem[req_idx] <= line_wdata;
    if (tag_we)  tag_mem[req_idx]  <= req_tag;
  end

  assign cpu_q       = rdata_q;
  assign cpu_done    = done_q;
  assign sdram_start = start_q;
  assign sdram_we    = swe_q;
  assign sdram_addr  = saddr_q;
  assign sdram_d     = sdata_q;
  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;

endmodule

// File: tb/tb_sdram_cache.sv
// tb/tb_sdram_cache.sv - scoreboard bench for sdram_cache with a behavioural SDRAM and cache model
module tb_sdram_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_start = 1'b0;
  logic        cpu_we = 1'b0;
  logic [23:0] cpu_addr = '0;
  logic [31:0] cpu_data = '0;
  logic [31:0] cpu_q;
  logic        cpu_done;
  logic        cache_clear = 1'b0;
  logic        sdram_start;
  logic        sdram_we;
  logic [23:0] sdram_addr;
  logic [31:0] sdram_d;
  logic [31:0] sdram_q = '0;
  logic        sdram_q_ready = 1'b0;
  logic        sdram_busy;
  logic        sdram_init_done = 1'b0;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  sdram_cache dut (
    .clk(clk), .reset(reset),
    .cpu_start(cpu_start), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_q(cpu_q), .cpu_done(cpu_done), .cache_clear(cache_clear),
    .sdram_start(sdram_start), .sdram_we(sdram_we), .sdram_addr(sdram_addr), .sdram_d(sdram_d),
    .sdram_q(sdram_q), .sdram_q_ready(sdram_q_ready), .sdram_busy(sdram_busy),
    .sdram_init_done(sdram_init_done), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [23:0] a);
    return {a[7:0] ^ 8'hC5, a};
  endfunction

  // SDRAM device: acts on negedge, variable latency, q_ready held until start drops.
  logic [31:0] dev_mem [logic [23:0]];
  int          dev_st = 0;
  int          dev_cnt = 0;
  int          acc_count = 0;
  logic        dev_busy = 1'b0;
  logic        force_busy = 1'b0;
  logic [23:0] cmd_addr = '0;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_d = '0;

  assign sdram_busy = dev_busy | force_busy;

  function automatic logic [31:0] dev_rd(input logic [23:0] a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return pat(a);
  endfunction

  always @(negedge clk) begin
    case (dev_st)
      0: if (sdram_start) begin
        check("start_before_init", 32'(sdram_init_done), 32'd1);
        check("start_while_busy", 32'(sdram_busy), 32'd0);
        acc_count++;
        cmd_addr = sdram_addr;
        cmd_we   = sdram_we;
        cmd_d    = sdram_d;
        if (sdram_we) dev_mem[sdram_addr] = sdram_d;
        dev_busy = 1'b1;
        dev_cnt  = $urandom_range(1, 4);
        dev_st   = 1;
      end
      1: if (!sdram_start) begin
        dev_busy = 1'b0;
        dev_st   = 0;
      end else begin
        check("sdram_addr_stable", 32'(sdram_addr), 32'(cmd_addr));
        dev_cnt--;
        if (dev_cnt == 0) begin
          sdram_q       = cmd_we ? $urandom : dev_rd(cmd_addr);
          sdram_q_ready = 1'b1;
          dev_st        = 2;
        end
      end
      default: if (!sdram_start) begin
        sdram_q_ready = 1'b0;
        dev_busy      = 1'b0;
        dev_st        = 0;
      end
    endcase
  end

  // Reference model: architectural memory plus per-line presence, no timing.
  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [31:0] data;
    logic [31:0] q;
    int          acc;
    logic [15:0] hits;
    logic [15:0] misses;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] ref_mem [logic [23:0]];
  bit          ref_valid [128];
  logic [16:0] ref_tag [128];
  logic [15:0] exp_hits = '0;
  logic [15:0] exp_miss = '0;

  function automatic logic [31:0] ref_rd(input logic [23:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return pat(a);
  endfunction

  task automatic model_invalidate();
    foreach (ref_valid[i]) ref_valid[i] = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [23:0] addr, input logic [31:0] data);
    exp_t e;
    int idx;
    logic [16:0] tg;
    bit hit;
    idx = int'(addr[6:0]);
    tg  = addr[23:7];
    hit = ref_valid[idx] && (ref_tag[idx] == tg);
    e.we = we; e.addr = addr; e.data = data; e.q = '0; e.acc = 1;
    if (we) begin
      ref_mem[addr] = data;
    end else begin
      e.q = ref_rd(addr);
      if (hit) begin
        exp_hits++;
        e.acc = 0;
      end else begin
        exp_miss++;
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tg;
      end
    end
    e.hits = exp_hits;
    e.misses = exp_miss;
    expq.push_back(e);
    cpu_we = we; cpu_addr = addr; cpu_data = data; cpu_start = 1'b1;
  endtask

  task automatic finish_req(input int hold, output int cyc);
    int acc0;
    int n;
    bit held;
    cyc = 0;
    while (!cpu_done && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!cpu_done) begin
      total++; bad++;
      $display("FAIL done_timeout: got 0 expected 1");
    end
    if (hold > 0) begin
      acc0 = acc_count;
      held = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (!cpu_done) held = 1'b0;
      end
      check("done_held", 32'(held), 32'd1);
      check("no_access_while_held", 32'(acc_count - acc0), 32'd0);
    end
    cpu_start = 1'b0;
    n = 0;
    while (cpu_done && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (cpu_done) begin
      total++; bad++;
      $display("FAIL done_release: got 1 expected 0");
    end
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 cache_clear = 1'b1;
    @(posedge clk); #1 cache_clear = 1'b0;
    model_invalidate();
  endtask

  // Monitor: one scoreboard entry per rising cpu_done.
  logic done_prev = 1'b0;
  int   last_acc = 0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!reset) begin
      done_prev = 1'b0;
      last_acc  = acc_count;
    end else begin
      if (cpu_done && !done_prev) begin
        if (expq.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = expq.pop_front();
          if (!mon_e.we) check("cpu_q", cpu_q, mon_e.q);
          check("hit_count", 32'(hit_count), 32'(mon_e.hits));
          check("miss_count", 32'(miss_count), 32'(mon_e.misses));
          check("sdram_accesses", 32'(acc_count - last_acc), 32'(mon_e.acc));
          if (mon_e.acc == 1) begin
            check("sdram_we", 32'(cmd_we), 32'(mon_e.we));
            check("sdram_addr", 32'(cmd_addr), 32'(mon_e.addr));
            if (mon_e.we) check("sdram_d", cmd_d, mon_e.data);
          end
          last_acc = acc_count;
        end
      end
      done_prev = cpu_done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [16:0] tgs [4];
  int          cyc;
  int          n;
  bit          saw;

  initial begin
    tgs[0] = 17'h00000; tgs[1] = 17'h00001; tgs[2] = 17'h00002; tgs[3] = 17'h1FFFF;
    dev_mem[24'h000010] = 32'hDEADBEEF;
    ref_mem[24'h000010] = 32'hDEADBEEF;
    model_invalidate();

    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_done", 32'(cpu_done), 32'd0);
    check("rst_cpu_q", cpu_q, 32'd0);
    check("rst_sdram_start", 32'(sdram_start), 32'd0);
    check("rst_sdram_we", 32'(sdram_we), 32'd0);
    check("rst_sdram_addr", 32'(sdram_addr), 32'd0);
    check("rst_sdram_d", sdram_d, 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_miss_count", 32'(miss_count), 32'd0);
    reset = 1'b1;

    // Controller not initialised: the miss must wait.
    @(posedge clk); #1;
    issue(1'b0, 24'h000010, '0);
    saw = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (sdram_start) saw = 1'b1;
    end
    check("no_start_before_init", 32'(saw), 32'd0);
    sdram_init_done = 1'b1;
    finish_req(0, cyc);

    @(posedge clk); #1;
    issue(1'b0, 24'h000010, '0);
    finish_req(0, cyc);
    check("hit_latency", 32'(cyc), 32'd2);

    @(posedge clk); #1; issue(1'b1, 24'h000010, 32'h12345678); finish_req(0, cyc);
    @(posedge clk); #1; issue(1'b0, 24'h000010, '0); finish_req(0, cyc);
    @(posedge clk); #1; issue(1'b0, 24'h000090, '0); finish_req(0, cyc);
    @(posedge clk); #1; issue(1'b0, 24'h000010, '0); finish_req(0, cyc);

    // Controller busy for 50 cycles during a miss, then cpu_start held past done.
    @(posedge clk); #1;
    force_busy = 1'b1;
    issue(1'b0, 24'h000123, '0);
    saw = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (sdram_start) saw = 1'b1;
    end
    check("no_start_while_busy", 32'(saw), 32'd0);
    force_busy = 1'b0;
    @(posedge clk); #1;
    check("start_after_busy", 32'(sdram_start), 32'd1);
    finish_req(5, cyc);

    pulse_clear();
    @(posedge clk); #1; issue(1'b0, 24'h000010, '0); finish_req(0, cyc);

    repeat (150) begin
      if ($urandom_range(0, 15) == 0) pulse_clear();
      @(posedge clk); #1;
      issue(1'b0 ^ ($urandom_range(0, 2) == 0), {tgs[$urandom_range(0, 3)], 7'($urandom_range(0, 7))}, $urandom);
      finish_req(0, cyc);
    end

    // Reset while a read is outstanding at the controller.
    @(posedge clk); #1; issue(1'b0, 24'h000010, '0); finish_req(0, cyc);
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 24'h00003A; cpu_start = 1'b1;
    n = 0;
    while (!sdram_start && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_mem_wait", 32'(sdram_start), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst_sdram_start", 32'(sdram_start), 32'd0);
    check("midrst_cpu_done", 32'(cpu_done), 32'd0);
    check("midrst_miss_count", 32'(miss_count), 32'd0);
    cpu_start = 1'b0;
    model_invalidate();
    exp_hits = '0;
    exp_miss = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1; issue(1'b0, 24'h00003A, '0); finish_req(0, cyc);
    @(posedge clk); #1; issue(1'b0, 24'h000010, '0); finish_req(0, cyc);
    @(posedge clk); #1; issue(1'b0, 24'h000010, '0); finish_req(0, cyc);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
